// File: rtl/pitchfall_sched.sv
// Time-multiplexed pitch-fall engine: one timer adder and threshold compare
// shared round-robin across VOICES channels, with per-voice state in arrays.
module pitchfall_sched #(
    parameter int unsigned VOICES   = 4,
    parameter int unsigned TIMER_W  = 26,
    parameter int unsigned THRESH   = 2097120,
    parameter int unsigned MAX_FALL = 24
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic [3:0]                  speed,
    input  logic [VOICES-1:0]           note_on,
    input  logic [VOICES-1:0]           note_repeat,
    input  logic [7*VOICES-1:0]         note_start,
    output logic [7*VOICES-1:0]         fall_amount,
    output logic [VOICES-1:0]           fall_step,
    output logic [$clog2(VOICES)-1:0]   slot
);

    localparam int unsigned SLOT_W = $clog2(VOICES);
    localparam int unsigned NOTE_W = 7;

    localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(VOICES - 1);
    localparam logic [TIMER_W-1:0] THRESH_V   = TIMER_W'(THRESH);
    localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(1);
    localparam logic [NOTE_W-1:0]  MAX_FALL_V = NOTE_W'(MAX_FALL);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_FALLING = 1'b1
    } state_t;

    state_t              state_q [VOICES];
    logic [TIMER_W-1:0]  timer_q [VOICES];
    logic [NOTE_W-1:0]   fall_q  [VOICES];
    logic [NOTE_W-1:0]   note_q  [VOICES];
    logic                rep_q   [VOICES];
    logic [SLOT_W-1:0]   slot_q;

    logic [NOTE_W-1:0]   note_in [VOICES];

    // Unpack the flat note bus and repack the per-voice fall registers.
    for (genvar g = 0; g < int'(VOICES); g++) begin : g_voice_io
        assign note_in[g]                       = note_start[g*NOTE_W +: NOTE_W];
        assign fall_amount[g*NOTE_W +: NOTE_W]  = fall_q[g];
    end

    assign slot = slot_q;

    // View of the voice being serviced this cycle.
    state_t             cur_state;
    logic [TIMER_W-1:0] cur_timer;
    logic [NOTE_W-1:0]  cur_fall;
    logic [NOTE_W-1:0]  cur_note;
    logic               cur_rep;
    logic               cur_on;
    logic               cur_rpt;
    logic [NOTE_W-1:0]  cur_start;
    logic [TIMER_W-1:0] timer_inc;

    assign cur_state = state_q[slot_q];
    assign cur_timer = timer_q[slot_q];
    assign cur_fall  = fall_q[slot_q];
    assign cur_note  = note_q[slot_q];
    assign cur_rep   = rep_q[slot_q];
    assign cur_on    = note_on[slot_q];
    assign cur_rpt   = note_repeat[slot_q];
    assign cur_start = note_in[slot_q];
    assign timer_inc = TIMER_INIT << speed;

    // Scheduler plus the per-voice FSM; only voice[slot_q] is touched per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q    <= '0;
            fall_step <= '0;
            for (int v = 0; v < int'(VOICES); v++) begin
                state_q[v] <= S_IDLE;
                timer_q[v] <= TIMER_INIT;
                fall_q[v]  <= '0;
                note_q[v]  <= '0;
                rep_q[v]   <= 1'b0;
            end
        end else begin
            fall_step <= '0;
            if (en) begin
                slot_q <= (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);

                if (!cur_on) begin
                    // Release: fall_amount holds, note memory is cleared.
                    state_q[slot_q] <= S_IDLE;
                    note_q[slot_q]  <= '0;
                    if (cur_note == cur_start) begin
                        rep_q[slot_q] <= cur_rpt;
                    end
                end else if (cur_state == S_IDLE) begin
                    if ((cur_start != cur_note) || cur_rep) begin
                        state_q[slot_q] <= S_FALLING;
                        fall_q[slot_q]  <= '0;
                        timer_q[slot_q] <= TIMER_INIT;
                        note_q[slot_q]  <= cur_start;
                        rep_q[slot_q]   <= 1'b0;
                    end
                end else if ((cur_start != cur_note) || cur_rpt) begin
                    // New note or retrigger: drop to IDLE, re-arm on the next visit.
                    state_q[slot_q] <= S_IDLE;
                    rep_q[slot_q]   <= cur_rpt;
                end else if (cur_fall < MAX_FALL_V) begin
                    if (cur_timer > THRESH_V) begin
                        fall_q[slot_q]    <= cur_fall + NOTE_W'(1);
                        timer_q[slot_q]   <= TIMER_INIT;
                        fall_step[slot_q] <= 1'b1;
                    end else begin
                        timer_q[slot_q] <= cur_timer + timer_inc;
                    end
                end
            end
        end
    end

endmodule

// File: doc/pitchfall_sched.md
Name: pitchfall_sched

Overview:
- Time-multiplexed pitch-fall engine: one shared timer adder/threshold comparator services VOICES channels round-robin.
- Per-voice state is held in register arrays: timer, fall count, latched note, repeat-pending flag, FSM state.
- Sits between the MIDI voice allocator and the per-channel pitch/frequency calculators. Each voice's fall_amount is subtracted from its note pitch downstream.

Parameters:
VOICES, 4, number of channels served; 2..16.
TIMER_W, 26, width of per-voice fall timer.
THRESH, 2097120, timer value that must be exceeded to take one fall step.
MAX_FALL, 24, saturation value of fall amount (semitones).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
en  in  1  global enable; low freezes scheduler and all voice state
speed  in  4  shared fall rate; per-visit timer increment = 1<<speed
note_on  in  VOICES  per-voice gate
note_repeat  in  VOICES  per-voice retrigger request (same note re-struck)
note_start  in  7*VOICES  per-voice MIDI note, voice v at [7v+6:7v]
fall_amount  out  7*VOICES  per-voice fall, registered, voice v at [7v+6:7v]
fall_step  out  VOICES  one-cycle pulse on the cycle voice v's fall_amount increments
slot  out  clog2(VOICES)  voice currently being serviced

Behaviour:
- Reset (async, reset_n=0): slot=0; every voice state=IDLE, timer=1, fall=0, note_reg=0, rep_pend=0; fall_amount=0; fall_step=0.
- Scheduler: when en=1, slot advances by 1 each clk, wrapping VOICES-1 -> 0. When en=0, slot holds, no voice updates, fall_step=0.
- Only voice[slot] is read/updated per cycle. Inputs of other voices are ignored until their visit. Worst-case input-to-response latency is VOICES cycles. The result is registered at the end of the visit cycle.
- Per-voice FSM, evaluated on visit. Priority: release > restart > fall.
  - Any state, note_on=0:
    - state<=IDLE; note_reg<=0.
    - If note_reg==note_start, rep_pend<=note_repeat.
    - fall_amount holds its value.
  - IDLE, note_on=1 and (note_start!=note_reg or rep_pend):
    - state<=FALLING; fall<=0; timer<=1; note_reg<=note_start; rep_pend<=0.
  - FALLING, note_on=1 and (note_start!=note_reg or note_repeat):
    - state<=IDLE; rep_pend<=note_repeat.
    - Re-arm occurs on the next visit, so a restart takes two visits.
  - FALLING otherwise, fall<MAX_FALL:
    - If the pre-update timer>THRESH: fall<=fall+1; timer<=1; fall_step[v] pulses.
    - Else timer<=timer+(1<<speed).
  - FALLING, fall==MAX_FALL: timer frozen, fall held (saturated). A restart or release still applies.
- Arithmetic: timer is unsigned TIMER_W. The add must not wrap for speed<=15 given the THRESH reset. fall is 7-bit and never exceeds MAX_FALL.
- speed is sampled at each visit; a change mid-fall affects subsequent increments only.
- Effective fall rate is 1/VOICES of a dedicated-per-voice engine. This is intended; software compensates via speed.
- Simultaneous events: several voices changing in the same cycle are each handled on their own visit; there is no loss.
- A note_on pulse shorter than VOICES cycles may be missed. Requesters must hold note_on for at least VOICES cycles.
- Note 0 after release: note_reg is cleared to 0, so re-striking note 0 starts only if rep_pend=1. This is accepted.
- Reset asserted mid-fall: all voices return to reset values immediately; no output pulse.

Test Plan:
1. Reset -> all fall_amount=0, fall_step=0, slot=0; with en=1, slot sequence 0,1,2,3,0.
2. VOICES=4, speed=15, voice1 note_on=1, note=60 held -> start at first visit. First fall_step[1] occurs 65 visits later (260 clk). fall_amount[1] reaches 24 after 1560 visits (6240 clk), then stays 24 with no further steps.
3. Voice0 falling, note_start changes 60->62 -> IDLE on next visit, restart at following visit. fall_amount[0]=0, timer=1, note_reg=62.
4. Voice2 note_on=1 note 64, then note_on=0 with note_repeat=1, then note_on=1 note 64 -> restarts (rep_pend path). Same sequence with note_repeat=0 -> also restarts, because note_reg was cleared on release.
5. en=0 for 100 clk mid-fall -> slot, timers and fall_amount unchanged; resume continues exactly where stopped.
6. All 4 voices note_on in the same cycle with distinct notes -> each starts on its own slot visit within 4 clk; fall_step pulses never coincide.
